// File: rtl/traffic_phase_sequencer_pkg.sv
// traffic_pkg: state type, index-width helpers and reset duration.
// Shared by the phase sequencer, its interface and its timer.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  localparam int DEFAULT_DUR = 3;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int tab_w(input int nsens);
    return idx_w(nsens + 1);
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Sensor, config and lamp-side signals of the phase sequencer.
// master drives sensors/config, slave is the sequencer.
interface traffic_phase_sequencer_if
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 8,
  parameter int NUM_SENSORS = 3,
  parameter int NUM_LAMPS   = 9,
  parameter int DUR_W       = 8
) ();

  localparam int PW = idx_w(NUM_PHASES);
  localparam int TW = tab_w(NUM_SENSORS);

  logic                   enable_general;
  logic [NUM_SENSORS-1:0] sensor;
  logic                   ped_req;
  logic                   clear_ok;
  logic                   cfg_we;
  logic [TW-1:0]          cfg_table;
  logic [PW-1:0]          cfg_phase;
  logic [DUR_W-1:0]       cfg_dur;
  logic [NUM_LAMPS-1:0]   cfg_mask;
  logic [PW-1:0]          phase;
  logic [TW-1:0]          table_sel;
  logic                   phase_start;
  logic [NUM_LAMPS-1:0]   lamp_toggle;
  logic                   lamp_set;
  logic                   holding;
  logic                   ped_pending;

  modport master (
    output enable_general, sensor, ped_req,
    output clear_ok, cfg_we, cfg_table,
    output cfg_phase, cfg_dur, cfg_mask,
    input  phase, table_sel, phase_start,
    input  lamp_toggle, lamp_set, holding,
    input  ped_pending
  );

  modport slave (
    input  enable_general, sensor, ped_req,
    input  clear_ok, cfg_we, cfg_table,
    input  cfg_phase, cfg_dur, cfg_mask,
    output phase, table_sel, phase_start,
    output lamp_toggle, lamp_set, holding,
    output ped_pending
  );

endinterface

// File: rtl/traffic_phase_sequencer_sec_timer.sv
// sec_timer: tick prescaler plus seconds counter for one phase.
// expire is high on the last cycle of a dur-second interval.
module sec_timer
  import traffic_pkg::*;
#(
  parameter int TICKS = 10000,
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [DUR_W-1:0] dur,
  output logic             expire
);

  localparam int PRE_W = idx_w(TICKS);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] sec_q, sec_d;
  logic             pre_wrap;

  assign pre_wrap = pre_q == PRE_W'(TICKS - 1);
  assign expire   = pre_wrap && (sec_q == dur - 1'b1);

  always_comb begin
    pre_d = pre_q;
    sec_d = sec_q;
    if (clr) begin
      pre_d = '0;
      sec_d = '0;
    end else if (run) begin
      pre_d = pre_wrap ? '0 : pre_q + 1'b1;
      if (pre_wrap) sec_d = sec_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      sec_q <= '0;
    end else begin
      pre_q <= pre_d;
      sec_q <= sec_d;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Timed phase sequencer with sensor-selected tables and hold phases.
// TRAFFIC_PHASE_SEQUENCER_PED_EN enables the pedestrian extension.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES    = 8,
  parameter int NUM_SENSORS   = 3,
  parameter int NUM_LAMPS     = 9,
  parameter int TICKS_PER_SEC = 10000,
  parameter int DUR_W         = 8,
  parameter int DEFAULT_DUR   = traffic_pkg::DEFAULT_DUR,
  parameter logic [NUM_PHASES-1:0] HOLD_MASK = 8'b1110_0000,
  parameter int PED_PHASE     = 0
) (
  input logic CLK,
  input logic reset_general,
  traffic_phase_sequencer_if.slave bus
);

  localparam int NT = NUM_SENSORS + 1;
  localparam int PW = idx_w(NUM_PHASES);
  localparam int TW = tab_w(NUM_SENSORS);

  state_t st_q, st_d;
  logic [PW-1:0] phase_q, phase_d, nxt, wrap;
  logic [TW-1:0] tsel_q, tsel_d, sens_tab, use_t;
  logic [DUR_W-1:0] dlat_q, dlat_d, raw, base;
  logic [DUR_W:0] dbl;
  logic [NUM_LAMPS-1:0] tog_q, tog_d;
  logic start_q, start_d, lset_q, lset_d;
  logic hold_q, hold_d, ped_q, ped_d;
  logic clr, run, enter, expire, ped_hit;

  logic [DUR_W-1:0] dur_q [NT][NUM_PHASES];
  logic [DUR_W-1:0] dur_d [NT][NUM_PHASES];
  logic [NUM_LAMPS-1:0] mask_q [NT][NUM_PHASES];
  logic [NUM_LAMPS-1:0] mask_d [NT][NUM_PHASES];

  sec_timer #(
    .TICKS(TICKS_PER_SEC),
    .DUR_W(DUR_W)
  ) u_timer (
    .clk   (CLK),
    .rst   (reset_general),
    .clr   (clr),
    .run   (run),
    .dur   (dlat_q),
    .expire(expire)
  );

  always_comb begin
    dur_d  = dur_q;
    mask_d = mask_q;
    if (bus.cfg_we && int'(bus.cfg_table) < NT
        && int'(bus.cfg_phase) < NUM_PHASES) begin
      dur_d[bus.cfg_table][bus.cfg_phase]  = bus.cfg_dur;
      mask_d[bus.cfg_table][bus.cfg_phase] = bus.cfg_mask;
    end
  end

  // Ambiguous sensor patterns fall back to table 0.
  always_comb begin
    sens_tab = '0;
    if ($onehot(bus.sensor))
      for (int i = 0; i < NUM_SENSORS; i++)
        if (bus.sensor[i]) sens_tab = TW'(i + 1);
  end

  always_comb begin
    st_d    = st_q;
    phase_d = phase_q;
    tsel_d  = tsel_q;
    dlat_d  = dlat_q;
    start_d = 1'b0;
    tog_d   = '0;
    lset_d  = 1'b0;
    hold_d  = 1'b0;
    clr     = 1'b0;
    run     = 1'b0;
    enter   = 1'b0;
    nxt     = '0;
    wrap    = (phase_q == PW'(NUM_PHASES - 1))
            ? '0 : phase_q + 1'b1;
    if (st_q != IDLE && !bus.enable_general) begin
      st_d    = IDLE;
      clr     = 1'b1;
      phase_d = '0;
      tsel_d  = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          clr = 1'b1;
          if (bus.enable_general) begin
            enter  = 1'b1;
            lset_d = 1'b1;
          end
        end
        RUN: begin
          if (!expire) begin
            run = 1'b1;
          end else if (!HOLD_MASK[phase_q] || bus.clear_ok) begin
            enter = 1'b1;
            nxt   = wrap;
          end else begin
            st_d   = HOLD;
            hold_d = 1'b1;
          end
        end
        HOLD: begin
          if (bus.clear_ok) begin
            enter = 1'b1;
            nxt   = wrap;
          end else begin
            hold_d = 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
    use_t   = (nxt == '0) ? sens_tab : tsel_q;
    raw     = dur_q[use_t][nxt];
    base    = (raw == '0) ? DUR_W'(1) : raw;
    dbl     = {base, 1'b0};
    ped_hit = enter && (nxt == PW'(PED_PHASE));
    if (enter) begin
      st_d    = RUN;
      clr     = 1'b1;
      phase_d = nxt;
      tsel_d  = use_t;
      start_d = 1'b1;
      tog_d   = mask_q[use_t][nxt];
      dlat_d  = base;
      if (ped_hit && ped_q)
        dlat_d = dbl[DUR_W] ? '1 : dbl[DUR_W-1:0];
    end
  end

`ifdef TRAFFIC_PHASE_SEQUENCER_PED_EN
  assign ped_d = bus.ped_req | (ped_q & ~ped_hit);
`else
  assign ped_d = bus.ped_req & 1'b0;
`endif

  always_ff @(posedge CLK or posedge reset_general) begin
    if (reset_general) begin
      st_q    <= IDLE;
      phase_q <= '0;
      tsel_q  <= '0;
      dlat_q  <= DUR_W'(1);
      tog_q   <= '0;
      start_q <= 1'b0;
      lset_q  <= 1'b0;
      hold_q  <= 1'b0;
      ped_q   <= 1'b0;
      for (int t = 0; t < NT; t++)
        for (int p = 0; p < NUM_PHASES; p++) begin
          dur_q[t][p]  <= DUR_W'(DEFAULT_DUR);
          mask_q[t][p] <= '0;
        end
    end else begin
      st_q    <= st_d;
      phase_q <= phase_d;
      tsel_q  <= tsel_d;
      dlat_q  <= dlat_d;
      tog_q   <= tog_d;
      start_q <= start_d;
      lset_q  <= lset_d;
      hold_q  <= hold_d;
      ped_q   <= ped_d;
      dur_q   <= dur_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.table_sel   = tsel_q;
  assign bus.phase_start = start_q;
  assign bus.lamp_toggle = tog_q;
  assign bus.lamp_set    = lset_q;
  assign bus.holding     = hold_q;
  assign bus.ped_pending = ped_q;

endmodule
